// File: rtl/alu_operand_stage_pkg.sv
// Shared ALU definitions: operation codes used by the ALU and by the operand stage,
// plus the register-match helper used for load-use hazard detection.
package alu_operand_stage_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int ALUSEL_W   = 4;

    typedef enum logic [ALUSEL_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_LUI  = 4'd10
    } alu_op_e;

    // True when a non-zero destination feeds either source register that is actually read.
    function automatic logic rd_match(
        input logic [REG_ADDR_W-1:0] rd,
        input logic                  uses_rs1,
        input logic [REG_ADDR_W-1:0] rs1,
        input logic                  uses_rs2,
        input logic [REG_ADDR_W-1:0] rs2
    );
        return (rd != '0) && ((uses_rs1 && (rs1 == rd)) || (uses_rs2 && (rs2 == rd)));
    endfunction

endpackage

// File: rtl/alu_operand_stage_forward.sv
// Per-operand bypass mux: picks the youngest in-flight result for a source register,
// with x0 always reading as zero.
module operand_forward
    import alu_operand_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [REG_ADDR_W-1:0] rs_addr,
    input  logic [XLEN-1:0]       rs_data,
    input  logic                  exmem_wen,
    input  logic [REG_ADDR_W-1:0] exmem_rd,
    input  logic [XLEN-1:0]       exmem_result,
    input  logic                  memwb_wen,
    input  logic [REG_ADDR_W-1:0] memwb_rd,
    input  logic [XLEN-1:0]       memwb_result,
    output logic [XLEN-1:0]       fwd_data
);

    // EX/MEM is the younger producer, so it wins over MEM/WB.
    always_comb begin
        fwd_data = rs_data;
        if (rs_addr == '0) begin
            fwd_data = '0;
        end else if (exmem_wen && (exmem_rd == rs_addr)) begin
            fwd_data = exmem_result;
        end else if (memwb_wen && (memwb_rd == rs_addr)) begin
            fwd_data = memwb_result;
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// Operand stage: single-entry registered buffer between decode and the ALU that
// resolves bypassing, stalls on load-use hazards and counts stall cycles.
module alu_operand_stage
    import alu_operand_stage_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int CNTW = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    input  logic [REG_ADDR_W-1:0] rd_addr,
    input  logic [XLEN-1:0]       rs1_data,
    input  logic [XLEN-1:0]       rs2_data,
    input  logic [XLEN-1:0]       imm,
    input  logic [XLEN-1:0]       pc,
    input  logic                  use_pc,
    input  logic                  use_imm,
    input  logic                  uses_rs1,
    input  logic                  uses_rs2,
    input  logic                  is_load,
    input  logic [ALUSEL_W-1:0]   alusel_in,
    input  logic                  exmem_wen,
    input  logic [REG_ADDR_W-1:0] exmem_rd,
    input  logic [XLEN-1:0]       exmem_result,
    input  logic                  memwb_wen,
    input  logic [REG_ADDR_W-1:0] memwb_rd,
    input  logic [XLEN-1:0]       memwb_result,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       reg1,
    output logic [XLEN-1:0]       reg2,
    output logic [ALUSEL_W-1:0]   ALUsel,
    output logic [REG_ADDR_W-1:0] rd_out,
    output logic                  is_load_out,
    output logic [CNTW-1:0]       stall_count
);

    logic                  out_valid_q, out_valid_d;
    logic [XLEN-1:0]       reg1_q, reg1_d;
    logic [XLEN-1:0]       reg2_q, reg2_d;
    alu_op_e               alusel_q, alusel_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic                  is_load_q, is_load_d;
    logic                  ld_pending_q, ld_pending_d;
    logic [REG_ADDR_W-1:0] ld_rd_q, ld_rd_d;
    logic [CNTW-1:0]       stall_count_q, stall_count_d;

    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;
    logic            hazard;
    logic            in_fire;
    logic            out_fire;

    operand_forward #(.XLEN(XLEN)) u_fwd_rs1 (
        .rs_addr      (rs1_addr),
        .rs_data      (rs1_data),
        .exmem_wen    (exmem_wen),
        .exmem_rd     (exmem_rd),
        .exmem_result (exmem_result),
        .memwb_wen    (memwb_wen),
        .memwb_rd     (memwb_rd),
        .memwb_result (memwb_result),
        .fwd_data     (fwd_rs1)
    );

    operand_forward #(.XLEN(XLEN)) u_fwd_rs2 (
        .rs_addr      (rs2_addr),
        .rs_data      (rs2_data),
        .exmem_wen    (exmem_wen),
        .exmem_rd     (exmem_rd),
        .exmem_result (exmem_result),
        .memwb_wen    (memwb_wen),
        .memwb_rd     (memwb_rd),
        .memwb_result (memwb_result),
        .fwd_data     (fwd_rs2)
    );

    // A load is unresolvable both while it sits here and for the cycle after it leaves.
    always_comb begin
        hazard = 1'b0;
        if (in_valid) begin
            if (out_valid_q && is_load_q &&
                rd_match(rd_q, uses_rs1, rs1_addr, uses_rs2, rs2_addr)) begin
                hazard = 1'b1;
            end
            if (ld_pending_q &&
                rd_match(ld_rd_q, uses_rs1, rs1_addr, uses_rs2, rs2_addr)) begin
                hazard = 1'b1;
            end
        end
    end

    assign in_ready = (!out_valid_q || out_ready) && !hazard && !flush;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid_q && out_ready;

    always_comb begin
        out_valid_d   = out_valid_q;
        reg1_d        = reg1_q;
        reg2_d        = reg2_q;
        alusel_d      = alusel_q;
        rd_d          = rd_q;
        is_load_d     = is_load_q;
        ld_pending_d  = 1'b0;
        ld_rd_d       = '0;
        stall_count_d = stall_count_q;

        if (flush) begin
            out_valid_d = 1'b0;
        end else if (in_fire) begin
            out_valid_d = 1'b1;
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end

        if (in_fire) begin
            reg1_d    = use_pc  ? pc  : fwd_rs1;
            reg2_d    = use_imm ? imm : fwd_rs2;
            alusel_d  = alu_op_e'(alusel_in);
            rd_d      = rd_addr;
            is_load_d = is_load;
        end

        if (!flush && out_fire && is_load_q) begin
            ld_pending_d = 1'b1;
            ld_rd_d      = rd_q;
        end

        if (hazard && (stall_count_q != {CNTW{1'b1}})) begin
            stall_count_d = stall_count_q + {{(CNTW-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q   <= 1'b0;
            reg1_q        <= '0;
            reg2_q        <= '0;
            alusel_q      <= ALU_ADD;
            rd_q          <= '0;
            is_load_q     <= 1'b0;
            ld_pending_q  <= 1'b0;
            ld_rd_q       <= '0;
            stall_count_q <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            reg1_q        <= reg1_d;
            reg2_q        <= reg2_d;
            alusel_q      <= alusel_d;
            rd_q          <= rd_d;
            is_load_q     <= is_load_d;
            ld_pending_q  <= ld_pending_d;
            ld_rd_q       <= ld_rd_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign reg1        = reg1_q;
    assign reg2        = reg2_q;
    assign ALUsel      = alusel_q;
    assign rd_out      = rd_q;
    assign is_load_out = is_load_q;
    assign stall_count = stall_count_q;

endmodule
